seq_detect_param: RTL



---
 rtl/seq_detect_param_pkg.sv | 30 +++
 rtl/seq_detect_param_if.sv | 46 ++++
 rtl/seq_detect_param_sat_counter.sv | 32 +++
 rtl/seq_detect_param.sv | 88 ++++++++
 4 files changed

// File: rtl/seq_detect_param_pkg.sv
// Shared constants, types and helpers for the parametrised sequence detector.
package seq_det_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

    // Widest pattern the mask helper can describe; detector instances stay at or below this.
    localparam int MAX_PAT_W = 64;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } det_mode_e;

    // Width needed to hold any length from 0 up to and including pat_w.
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Mask with the low n bits set; callers size-cast the result down to their pattern width.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input int n);
        logic [MAX_PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PAT_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Configuration, serial data and detect-status bundle for seq_detect_param.
// The master side is whatever feeds the bit stream and reads the status back.
interface seq_detect_param_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);

    localparam int LEN_W = calc_len_w(PAT_W);

    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap_en;
    logic             din_valid;
    logic             din;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output cfg_load,
        output pattern,
        output len,
        output overlap_en,
        output din_valid,
        output din,
        input  y,
        input  match_cnt,
        input  cnt_sat
    );

    modport slave (
        input  cfg_load,
        input  pattern,
        input  len,
        input  overlap_en,
        input  din_valid,
        input  din,
        output y,
        output match_cnt,
        output cnt_sat
    );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter: clears on rst or clr, increments on inc, sticks at all ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat = &r_count;

    // Count register; reset and clear win over increment, and a full counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + W'(1);
        end
    end

    assign q   = r_count;
    assign sat = w_sat;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable Moore sequence detector for a qualified serial bit stream.
// The pattern is matched MSB-first against the most recent accepted bits, with
// overlapping or non-overlapping detection and a saturating match count.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);

    localparam int               LEN_W    = calc_len_w(PAT_W);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_shreg;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    det_mode_e        r_mode;
    logic             r_y;

    logic [PAT_W-1:0] w_nsh;
    logic [LEN_W-1:0] w_nfill;
    logic [PAT_W-1:0] w_mask;
    logic             w_hit;
    logic             w_accept;
    logic [LEN_W-1:0] w_loadLen;
    logic [CNT_W-1:0] w_cnt;
    logic             w_sat;

    // A bit is taken only when no configuration load competes with it.
    assign w_accept = bus.din_valid && !bus.cfg_load;

    // Zero or out-of-range lengths fall back to the full pattern width.
    assign w_loadLen = ((bus.len == '0) || (bus.len > FULL_LEN)) ? FULL_LEN : bus.len;

    // Shift the new bit in at the bottom; the oldest bit drops off the top.
    assign w_nsh = PAT_W'({r_shreg, bus.din});

    // Fill counts real history since the last flush so stale shreg bits never match.
    assign w_nfill = (r_fill >= FULL_LEN) ? FULL_LEN : (r_fill + LEN_W'(1));

    assign w_mask = PAT_W'(len_mask(int'(r_len)));

    assign w_hit = (w_nfill >= r_len) && ((w_nsh & w_mask) == (r_pat & w_mask));

    // Detector state: reset, then configuration flush, then accepted bits; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_len   <= FULL_LEN;
            r_mode  <= MODE_OVERLAP;
            r_y     <= 1'b0;
        end else if (bus.cfg_load) begin
            r_pat   <= bus.pattern;
            r_len   <= w_loadLen;
            r_mode  <= bus.overlap_en ? MODE_OVERLAP : MODE_NON_OVERLAP;
            r_shreg <= '0;
            r_fill  <= '0;
            r_y     <= 1'b0;
        end else if (bus.din_valid) begin
            r_shreg <= w_nsh;
            r_y     <= w_hit;
            r_fill  <= (w_hit && (r_mode == MODE_NON_OVERLAP)) ? '0 : w_nfill;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_matchCnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cfg_load),
        .inc (w_accept && w_hit),
        .q   (w_cnt),
        .sat (w_sat)
    );

    assign bus.y         = r_y;
    assign bus.match_cnt = w_cnt;
    assign bus.cnt_sat   = w_sat;

endmodule
